// File: rtl/uart_rx_packet_ctrl.sv
// Frame receiver for a byte-oriented UART: SYNC, CMD, LEN, payload, XOR checksum.
// A checked frame is held on cmd_* / rd_data until the consumer accepts it.
//
// state   | meaning
// HUNT    | waiting for SYNC_BYTE, other bytes dropped silently
// GET_CMD | next byte is the command
// GET_LEN | next byte is the payload length
// GET_PAY | collecting payload bytes into the buffer
// GET_CHK | next byte is compared with the running XOR
// HOLD    | frame valid and frozen until cmd_ready
module uart_rx_packet_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 8,
  localparam int        AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_data_ready,
  input  logic [7:0]    rx_data,
  input  logic          rx_endofpacket,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [7:0]    cmd_op,
  output logic [4:0]    cmd_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_trunc,
  output logic          err_ovr
);

  typedef enum logic [2:0] {HUNT, GET_CMD, GET_LEN, GET_PAY, GET_CHK, HOLD} state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t      state, state_next;
  logic [7:0]  chk_acc;
  logic [4:0]  pay_idx;
  logic [7:0]  pay_mem [MAX_LEN];
  logic        take_cmd, take_len, take_pay;
  logic        err_chk_next, err_len_next, err_trunc_next, err_ovr_next;

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    take_cmd       = 1'b0;
    take_len       = 1'b0;
    take_pay       = 1'b0;
    err_chk_next   = 1'b0;
    err_len_next   = 1'b0;
    err_trunc_next = 1'b0;
    err_ovr_next   = 1'b0;
    case (state)
      HUNT: begin
        if (rx_data_ready && rx_data == SYNC_BYTE) state_next = GET_CMD;
      end
      GET_CMD: begin
        if (rx_endofpacket) begin
          err_trunc_next = 1'b1;
          state_next     = HUNT;
        end else if (rx_data_ready) begin
          take_cmd   = 1'b1;
          state_next = GET_LEN;
        end
      end
      GET_LEN: begin
        if (rx_endofpacket) begin
          err_trunc_next = 1'b1;
          state_next     = HUNT;
        end else if (rx_data_ready) begin
          if (rx_data > MAX_LEN_B) begin
            err_len_next = 1'b1;
            state_next   = HUNT;
          end else begin
            take_len   = 1'b1;
            state_next = (rx_data == 8'd0) ? GET_CHK : GET_PAY;
          end
        end
      end
      GET_PAY: begin
        if (rx_endofpacket) begin
          err_trunc_next = 1'b1;
          state_next     = HUNT;
        end else if (rx_data_ready) begin
          take_pay = 1'b1;
          if (pay_idx == cmd_len - 5'd1) state_next = GET_CHK;
        end
      end
      GET_CHK: begin
        if (rx_endofpacket) begin
          err_trunc_next = 1'b1;
          state_next     = HUNT;
        end else if (rx_data_ready) begin
          if (rx_data == chk_acc) begin
            state_next = HOLD;
          end else begin
            err_chk_next = 1'b1;
            state_next   = HUNT;
          end
        end
      end
      HOLD: begin
        // Bytes arriving while a frame is held are lost, including in the release cycle.
        if (rx_data_ready) err_ovr_next = 1'b1;
        if (cmd_ready)     state_next   = HUNT;
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_op    <= 8'd0;
      cmd_len   <= 5'd0;
      chk_acc   <= 8'd0;
      pay_idx   <= 5'd0;
      err_chk   <= 1'b0;
      err_len   <= 1'b0;
      err_trunc <= 1'b0;
      err_ovr   <= 1'b0;
    end else begin
      err_chk   <= err_chk_next;
      err_len   <= err_len_next;
      err_trunc <= err_trunc_next;
      err_ovr   <= err_ovr_next;
      if (take_cmd) begin
        cmd_op  <= rx_data;
        chk_acc <= rx_data;
      end
      if (take_len) begin
        cmd_len <= rx_data[4:0];
        chk_acc <= chk_acc ^ rx_data;
        pay_idx <= 5'd0;
      end
      if (take_pay) begin
        chk_acc <= chk_acc ^ rx_data;
        pay_idx <= pay_idx + 5'd1;
      end
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && take_pay) pay_mem[pay_idx[AW-1:0]] <= rx_data;
  end

  assign rd_data   = pay_mem[rd_addr];
  assign cmd_valid = (state == HOLD);

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed bench for uart_rx_packet_ctrl: good/bad frames, errors, overrun, reset.
module tb_uart_rx_packet_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       rx_endofpacket;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_op;
  logic [4:0] cmd_len;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       err_chk, err_len, err_trunc, err_ovr;

  int total = 0;
  int bad   = 0;
  int n_chk = 0, n_len = 0, n_trunc = 0, n_ovr = 0, n_multi = 0;
  int s_chk, s_len, s_trunc, s_ovr;

  uart_rx_packet_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .rx_data_ready(rx_data_ready), .rx_data(rx_data), .rx_endofpacket(rx_endofpacket),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .err_chk(err_chk), .err_len(err_len), .err_trunc(err_trunc), .err_ovr(err_ovr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_chk)   n_chk++;
    if (err_len)   n_len++;
    if (err_trunc) n_trunc++;
    if (err_ovr)   n_ovr++;
    if (32'(err_chk) + 32'(err_len) + 32'(err_trunc) + 32'(err_ovr) > 1) n_multi++;
  end

  task automatic snap();
    s_chk = n_chk; s_len = n_len; s_trunc = n_trunc; s_ovr = n_ovr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_data_ready = 1'b1;
    @(posedge clk); #1;
    rx_data_ready = 1'b0; rx_data = 8'h00;
  endtask

  task automatic pulse_eop();
    rx_endofpacket = 1'b1;
    @(posedge clk); #1;
    rx_endofpacket = 1'b0;
  endtask

  task automatic release_frame(input string nm);
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    total++;
    if (cmd_valid !== 1'b0) begin
      bad++; $display("FAIL %s_release: cmd_valid=%b want 0", nm, cmd_valid);
    end
  endtask

  task automatic chk_errs(input string nm, input int e_chk, input int e_len,
                          input int e_trunc, input int e_ovr);
    total++;
    if ((n_chk - s_chk) !== e_chk || (n_len - s_len) !== e_len ||
        (n_trunc - s_trunc) !== e_trunc || (n_ovr - s_ovr) !== e_ovr) begin
      bad++;
      $display("FAIL %s_errs: chk/len/trunc/ovr=%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", nm,
               n_chk - s_chk, n_len - s_len, n_trunc - s_trunc, n_ovr - s_ovr,
               e_chk, e_len, e_trunc, e_ovr);
    end
  endtask

  // Sends A5, op, 03, 11, 22, 33, chk=op^03^11^22^33 and checks delivery.
  task automatic frame_3(input string nm, input logic [7:0] op);
    logic [7:0] ck;
    logic [7:0] pl [3];
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    ck = op ^ 8'h03 ^ 8'h11 ^ 8'h22 ^ 8'h33;
    send_byte(8'hA5); send_byte(op); send_byte(8'h03);
    for (int i = 0; i < 3; i++) send_byte(pl[i]);
    total++;
    if (cmd_valid !== 1'b0) begin
      bad++; $display("FAIL %s_early: cmd_valid=%b want 0", nm, cmd_valid);
    end
    send_byte(ck);
    total++;
    if (cmd_valid !== 1'b1 || cmd_op !== op || cmd_len !== 5'd3) begin
      bad++;
      $display("FAIL %s_hold: valid=%b op=%h len=%0d want 1 %h 3", nm, cmd_valid, cmd_op, cmd_len, op);
    end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 3'(i); #1;
      total++;
      if (rd_data !== pl[i]) begin
        bad++; $display("FAIL %s_rd%0d: rd_data=%h want %h", nm, i, rd_data, pl[i]);
      end
    end
  endtask

  task automatic test_reset();
    total++;
    if (cmd_valid !== 1'b0 || cmd_op !== 8'h00 || cmd_len !== 5'd0 ||
        {err_chk, err_len, err_trunc, err_ovr} !== 4'b0000) begin
      bad++;
      $display("FAIL reset: valid=%b op=%h len=%0d errs=%b want 0 00 0 0000", cmd_valid, cmd_op,
               cmd_len, {err_chk, err_len, err_trunc, err_ovr});
    end
  endtask

  task automatic test_good_frame();
    snap();
    frame_3("good", 8'h10);
    idle(3);
    total++;
    if (cmd_valid !== 1'b1) begin
      bad++; $display("FAIL good_wait: cmd_valid=%b want 1", cmd_valid);
    end
    release_frame("good");
    idle(1);
    chk_errs("good", 0, 0, 0, 0);
  endtask

  task automatic test_bad_chk();
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01); send_byte(8'hFF); send_byte(8'h00);
    idle(2);
    total++;
    if (cmd_valid !== 1'b0) begin
      bad++; $display("FAIL badchk_valid: cmd_valid=%b want 0", cmd_valid);
    end
    chk_errs("badchk", 1, 0, 0, 0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    total++;
    if (cmd_valid !== 1'b1 || cmd_op !== 8'h02 || cmd_len !== 5'd0) begin
      bad++;
      $display("FAIL len0: valid=%b op=%h len=%0d want 1 02 0", cmd_valid, cmd_op, cmd_len);
    end
    release_frame("len0");
  endtask

  task automatic test_len_err();
    logic [7:0] junk [10];
    junk = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h10};
    snap();
    cmd_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h09);
    for (int i = 0; i < 10; i++) send_byte(junk[i]);
    cmd_ready = 1'b0;
    idle(2);
    total++;
    if (cmd_valid !== 1'b0) begin
      bad++; $display("FAIL lenerr_valid: cmd_valid=%b want 0", cmd_valid);
    end
    chk_errs("lenerr", 0, 1, 0, 0);
    // LEN equal to MAX_LEN is still legal: 01..08, chk = 07^08^(01^..^08)=07^08^08=07
    snap();
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h08);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    send_byte(8'h07);
    rd_addr = 3'd7; #1;
    total++;
    if (cmd_valid !== 1'b1 || cmd_len !== 5'd8 || rd_data !== 8'h08) begin
      bad++;
      $display("FAIL maxlen: valid=%b len=%0d rd7=%h want 1 8 08", cmd_valid, cmd_len, rd_data);
    end
    release_frame("maxlen");
    idle(1);
    chk_errs("maxlen", 0, 0, 0, 0);
  endtask

  task automatic test_trunc();
    snap();
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h04); send_byte(8'h01);
    pulse_eop();
    idle(2);
    chk_errs("trunc", 0, 0, 1, 0);
    // Abort beats a byte in the same cycle; that byte must not count as CMD.
    snap();
    send_byte(8'hA5);
    rx_endofpacket = 1'b1;
    send_byte(8'h10);
    rx_endofpacket = 1'b0;
    pulse_eop();
    idle(2);
    chk_errs("trunc_same", 0, 0, 1, 0);
    snap();
    frame_3("after_trunc", 8'h10);
    pulse_eop();
    total++;
    if (cmd_valid !== 1'b1) begin
      bad++; $display("FAIL eop_hold: cmd_valid=%b want 1", cmd_valid);
    end
    release_frame("after_trunc");
    idle(1);
    chk_errs("after_trunc", 0, 0, 0, 0);
  endtask

  task automatic test_overrun();
    snap();
    frame_3("ovr", 8'h5C);
    send_byte(8'hA5); idle(1);
    send_byte(8'h10); send_byte(8'h03);
    idle(2);
    chk_errs("ovr", 0, 0, 0, 3);
    total++;
    if (cmd_valid !== 1'b1 || cmd_op !== 8'h5C || cmd_len !== 5'd3) begin
      bad++;
      $display("FAIL ovr_frozen: valid=%b op=%h len=%0d want 1 5c 3", cmd_valid, cmd_op, cmd_len);
    end
    rd_addr = 3'd1; #1;
    total++;
    if (rd_data !== 8'h22) begin
      bad++; $display("FAIL ovr_rd1: rd_data=%h want 22", rd_data);
    end
  endtask

  task automatic test_back_to_back();
    snap();
    cmd_ready = 1'b1;
    send_byte(8'hA5);
    cmd_ready = 1'b0;
    total++;
    if (cmd_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_release: cmd_valid=%b want 0", cmd_valid);
    end
    frame_3("b2b", 8'h66);
    release_frame("b2b");
    idle(1);
    chk_errs("b2b", 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
    rst = 1'b1;
    rx_data = 8'h22; rx_data_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rx_data_ready = 1'b0;
    total++;
    if (cmd_len !== 5'd0 || cmd_op !== 8'h00) begin
      bad++; $display("FAIL rstmid_clear: op=%h len=%0d want 00 0", cmd_op, cmd_len);
    end
    frame_3("rstmid", 8'h10);
    release_frame("rstmid");
    idle(1);
    chk_errs("rstmid", 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; rx_data_ready = 1'b0; rx_data = 8'h00; rx_endofpacket = 1'b0;
    cmd_ready = 1'b0; rd_addr = 3'd0;
    idle(2);
    test_reset();
    rst = 1'b0;
    idle(1);
    test_good_frame();
    test_bad_chk();
    test_len_err();
    test_trunc();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (n_multi !== 0) begin
      bad++; $display("FAIL one_err_per_cycle: cycles=%0d want 0", n_multi);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
